// File: rtl/uart_frame_rx_if.sv
// Byte-stream bundle between the RX FIFO, the frame parser and the payload consumer.
// The master side is the parser; the slave side is the FIFO/consumer environment.
interface uart_frame_rx_if #(
   parameter int unsigned D_BIT = 8
);
   logic             rx_empty;
   logic [D_BIT-1:0] r_data;
   logic             rd_uart;
   logic [D_BIT-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             frame_ok;
   logic             frame_err;
   logic             busy;

   modport master (
      input  rx_empty, r_data, out_ready,
      output rd_uart, out_data, out_valid, frame_ok, frame_err, busy
   );

   modport slave (
      output rx_empty, r_data, out_ready,
      input  rd_uart, out_data, out_valid, frame_ok, frame_err, busy
   );
endinterface

// File: rtl/uart_frame_rx.sv
// Frame parser behind the UART RX FIFO: SOF / LEN / payload / XOR-checksum framing,
// payload streamed on a valid/ready port, per-frame ok/err pulses, inter-byte timeout.
module uart_frame_rx #(
   parameter int unsigned      D_BIT   = 8,
   parameter logic [D_BIT-1:0] SOF     = 8'hAA,
   parameter int unsigned      MAX_LEN = 64,
   parameter int unsigned      TO_CYC  = 50000,
   parameter int unsigned      TO_W    = 16
) (
   input  logic            clk,
   input  logic            rst,
   uart_frame_rx_if.master bus
);
   typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} state_t;

   localparam logic [D_BIT-1:0] MAX_LEN_B = D_BIT'(MAX_LEN);
   localparam logic [D_BIT-1:0] ONE_B     = D_BIT'(1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);

   state_t           state;
   logic [D_BIT-1:0] cnt;
   logic [D_BIT-1:0] chk_acc;
   logic [TO_W-1:0]  to_cnt;
   logic             can_take;
   logic             take;
   logic [D_BIT-1:0] b;

   // Only the payload stage can be back-pressured by the output register.
   assign can_take    = (state == PAYLOAD) ? (~bus.out_valid | bus.out_ready) : 1'b1;
   assign take        = ~bus.rx_empty & can_take;
   assign bus.rd_uart = take;
   assign bus.busy    = (state != IDLE);
   assign b           = bus.r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         chk_acc       <= '0;
         to_cnt        <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.frame_ok  <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         bus.frame_ok  <= 1'b0;
         bus.frame_err <= 1'b0;
         // A payload byte taken this cycle re-asserts valid below, so no bubble.
         if (bus.out_ready)
            bus.out_valid <= 1'b0;

         if (state == IDLE || take)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;

         if (take) begin
            case (state)
               IDLE: begin
                  chk_acc <= '0;
                  if (b == SOF)
                     state <= LEN;
               end
               LEN: begin
                  cnt     <= b;
                  chk_acc <= b;
                  if (b > MAX_LEN_B) begin
                     state         <= IDLE;
                     bus.frame_err <= 1'b1;
                  end else if (b == '0) begin
                     state <= CHK;
                  end else begin
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  bus.out_data  <= b;
                  bus.out_valid <= 1'b1;
                  chk_acc       <= chk_acc ^ b;
                  cnt           <= cnt - ONE_B;
                  if (cnt == ONE_B)
                     state <= CHK;
               end
               CHK: begin
                  state <= IDLE;
                  if (b == chk_acc)
                     bus.frame_ok  <= 1'b1;
                  else
                     bus.frame_err <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE && to_cnt == TO_LAST) begin
            state         <= IDLE;
            bus.frame_err <= 1'b1;
         end
      end
   end
endmodule
